fifo_reader: RTL and testbench
==============================

// Module: fifo_reader
// PURPOSE
// - Consumer end of the fifo read port: pops words whenever the fifo is non-empty and
//   the block is enabled, and presents each word downstream on a valid/ready handshake.
// - Sits between fifo (readflag/emptyflag/readdata) and any 32-bit word consumer.
// - Hides fifo read latency; at most one word in flight, never pops while holding a word.
// PARAMETERS
// - DATA_W  32  width of fifo words and downstream data
// - RD_LAT  1   cycles from readflag high at a clock edge to valid readdata (1..4)
// - CNT_W   16  width of delivered-word counter (FIFO_READER_CNT_EN only)
// PORTS
// - fifo_reader_clk_i        in   1       single clock, all logic on rising edge
// - fifo_reader_rst_i        in   1       synchronous, active-high reset
// - fifo_reader_en_i         in   1       1 = allowed to start new pops
// - fifo_reader_emptyflag_i  in   1       fifo empty flag
// - fifo_reader_readdata_i   in   DATA_W  fifo read data
// - fifo_reader_readflag_o   out  1       fifo pop strobe, one-cycle pulse per word
// - fifo_reader_valid_o      out  1       downstream word valid
// - fifo_reader_ready_i      in   1       downstream accepts word
// - fifo_reader_data_o       out  DATA_W  downstream word, stable while valid_o=1
// - fifo_reader_busy_o       out  1       1 in any state other than IDLE
// - fifo_reader_count_o      out  CNT_W   delivered words (FIFO_READER_CNT_EN only)
// BEHAVIOUR
// - Reset values: readflag_o=0, valid_o=0, data_o=0, busy_o=0, count_o=0, state=IDLE.
// - FSM states: IDLE, POP, WAIT, HOLD.
//   IDLE: if en_i=1 and emptyflag_i=0 -> POP; otherwise stay in IDLE.
//   POP : readflag_o=1 for exactly this cycle; -> WAIT; latency counter loaded with RD_LAT.
//   WAIT: count down; when the counter expires, capture readdata_i into data_o, set valid_o=1,
//         -> HOLD. RD_LAT=1: capture on the first WAIT edge.
//   HOLD: valid_o=1, data_o frozen; on ready_i=1 at an edge -> valid_o=0 and
//         return to IDLE.
// - Handshake: transfer occurs only on an edge with valid_o=1 and ready_i=1.
//   valid_o never drops without a transfer (except reset). ready_i is ignored while
//   valid_o=0.
// - Throughput: one word per RD_LAT+3 cycles at best (IDLE, POP, WAIT x RD_LAT, HOLD).
//   No back-to-back pops.
// - Empty: readflag_o is never asserted while emptyflag_i=1 is sampled in IDLE.
//   The emptyflag update after a pop is never re-sampled before WAIT has completed.
// - en_i drop: blocks only the IDLE->POP transition. A word already popped completes
//   through WAIT/HOLD and is delivered.
// - Reset mid-operation: immediate return to IDLE. An in-flight or held word is discarded
//   (accepted loss). readflag_o is 0 on the cycle after the reset edge.
// - data_o keeps its last value after the transfer. Only valid_o qualifies it.
// CONFIGURATION
// - Macro FIFO_READER_CNT_EN:
//   Defined: count_o increments by 1 on each handshake transfer, saturates at
//   2^CNT_W-1, and clears on reset.
//   Undefined: the count_o port and counter logic are absent.
// STRUCTURE
// - Package fifo_reader_pkg: state enum (IDLE=2'd0, POP=2'd1, WAIT=2'd2, HOLD=2'd3),
//   DATA_W and RD_LAT defaults, max-latency constant 4.
// - Single module, no sub-modules. The latency counter is 3 bits, sized for RD_LAT<=4.
// TESTING
// - Reset held 2 cycles, fifo empty -> readflag_o=0, valid_o=0, busy_o=0 throughout.
// - Fifo model holds 0x0000AD00, ready_i=1 -> one readflag pulse, then
//   valid_o=1 with data 0x0000AD00 RD_LAT+1 edges after the pulse; empty -> idle.
// - Fifo holds 0x1,0x2,0x3,0x5, ready_i=1 -> four pulses, each exactly RD_LAT+3 cycles
//   apart; words delivered in order 1,2,3,5. Count=4 with FIFO_READER_CNT_EN.
// - ready_i=0 for 10 cycles during HOLD -> data_o stable, no further readflag, single
//   transfer on ready rise.
// - en_i=0 asserted the cycle after POP -> current word delivered, no new pop while
//   en_i=0 even with emptyflag_i=0.
// - Reset asserted in WAIT and in HOLD -> valid_o=0 next cycle, state IDLE, word dropped.
//   Sweep RD_LAT=1,2,4.

Source files
------------

// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the fifo_reader block: FSM state encoding,
// default widths and the maximum fifo read latency the block supports.
package fifo_reader_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int RD_LAT_DEF = 1;
   localparam int RD_LAT_MAX = 4;
   // Latency down-counter width, large enough to hold RD_LAT_MAX.
   localparam int LAT_CNT_W  = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      POP  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } state_t;

endpackage

// File: rtl/fifo_reader.sv
// fifo_reader: consumer end of a fifo read port. Pops one word at a time,
// waits out the fifo read latency, then offers the word downstream on a
// valid/ready handshake. Only one word is ever in flight.
// Optional feature: define FIFO_READER_CNT_EN to add a saturating counter of
// delivered words on fifo_reader_count_o (and the CNT_W parameter).
module fifo_reader
   import fifo_reader_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int RD_LAT = RD_LAT_DEF
`ifdef FIFO_READER_CNT_EN
   ,
   parameter int CNT_W  = 16
`endif
)(
   input  logic              fifo_reader_clk_i,
   input  logic              fifo_reader_rst_i,
   input  logic              fifo_reader_en_i,
   input  logic              fifo_reader_emptyflag_i,
   input  logic [DATA_W-1:0] fifo_reader_readdata_i,
   output logic              fifo_reader_readflag_o,
   output logic              fifo_reader_valid_o,
   input  logic              fifo_reader_ready_i,
   output logic [DATA_W-1:0] fifo_reader_data_o,
   output logic              fifo_reader_busy_o
`ifdef FIFO_READER_CNT_EN
   ,
   output logic [CNT_W-1:0]  fifo_reader_count_o
`endif
);

   // Clamp the latency into the range the 3-bit counter can represent.
   localparam int LAT_EFF = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX :
                            (RD_LAT < 1)          ? 1          : RD_LAT;
   localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(LAT_EFF);

   state_t                 state_reg, state_next;
   logic [LAT_CNT_W-1:0]   lat_cnt_reg, lat_cnt_next;
   logic [DATA_W-1:0]      data_reg, data_next;
   logic                   readflag_next;
   logic                   valid_next;

   // State, latency counter and captured word registers.
   always_ff @(posedge fifo_reader_clk_i) begin
      if (fifo_reader_rst_i) begin
         state_reg   <= IDLE;
         lat_cnt_reg <= '0;
         data_reg    <= '0;
      end else begin
         state_reg   <= state_next;
         lat_cnt_reg <= lat_cnt_next;
         data_reg    <= data_next;
      end
   end

   // Next-state logic and state-decoded strobes. The empty flag is only looked
   // at in IDLE, so its update after a pop is never seen until the word is out.
   always_comb begin
      state_next    = state_reg;
      lat_cnt_next  = lat_cnt_reg;
      data_next     = data_reg;
      readflag_next = 1'b0;
      valid_next    = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (fifo_reader_en_i && !fifo_reader_emptyflag_i) begin
               state_next = POP;
            end
         end
         POP: begin
            readflag_next = 1'b1;
            lat_cnt_next  = LAT_LOAD;
            state_next    = WAIT;
         end
         WAIT: begin
            if (lat_cnt_reg <= LAT_CNT_W'(1)) begin
               data_next  = fifo_reader_readdata_i;
               state_next = HOLD;
            end else begin
               lat_cnt_next = lat_cnt_reg - LAT_CNT_W'(1);
            end
         end
         HOLD: begin
            valid_next = 1'b1;
            if (fifo_reader_ready_i) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign fifo_reader_readflag_o = readflag_next;
   assign fifo_reader_valid_o    = valid_next;
   assign fifo_reader_data_o     = data_reg;
   assign fifo_reader_busy_o     = (state_reg != IDLE);

`ifdef FIFO_READER_CNT_EN
   logic [CNT_W-1:0] count_reg;

   // Delivered-word counter: one step per handshake, sticks at all-ones.
   always_ff @(posedge fifo_reader_clk_i) begin
      if (fifo_reader_rst_i) begin
         count_reg <= '0;
      end else if ((state_reg == HOLD) && fifo_reader_ready_i && (count_reg != '1)) begin
         count_reg <= count_reg + CNT_W'(1);
      end
   end

   assign fifo_reader_count_o = count_reg;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader. Three instances (RD_LAT = 1, 2, 4) are
// exercised one after another; each has a fifo model and a protocol/scoreboard
// monitor. Define FIFO_READER_CNT_EN to also check the delivered-word counter.
module tb_fifo_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   // Stimulus and DUT-facing signals, one slot per lane.
   logic        rst_s   [3];
   logic        en_s    [3];
   logic        ready_s [3];
   logic        empty_s [3];
   logic [31:0] rdata_s [3];
   logic        rf_w    [3];
   logic        valid_w [3];
   logic        busy_w  [3];
   logic [31:0] data_w  [3];
`ifdef FIFO_READER_CNT_EN
   logic [15:0] count_w [3];
`endif

   // Fifo contents / scoreboard per lane: words pushed at wr_ptr, popped at
   // rd_ptr, expected downstream at exp_ptr (advanced on delivery or drop).
   logic [31:0] mem     [3][256];
   int          wr_ptr  [3];
   int          rd_ptr  [3];
   int          exp_ptr [3];
   int          deliv   [3];
   int          pop_n   [3];
   int          pop_log [3][16];

   function automatic int lat_of(input int ln);
      return (ln == 0) ? 1 : (ln == 1) ? 2 : 4;
   endfunction

   function automatic string tg(input int ln, input string s);
      return $sformatf("rl%0d_%s", lat_of(ln), s);
   endfunction

   task automatic check(input string tag, input longint obs, input longint exp);
      n_tests++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   for (genvar gi = 0; gi < 3; gi++) begin : g_lane
      localparam int L = (gi == 0) ? 1 : (gi == 1) ? 2 : 4;

      fifo_reader #(.DATA_W(32), .RD_LAT(L)) u_dut (
         .fifo_reader_clk_i       (clk),
         .fifo_reader_rst_i       (rst_s[gi]),
         .fifo_reader_en_i        (en_s[gi]),
         .fifo_reader_emptyflag_i (empty_s[gi]),
         .fifo_reader_readdata_i  (rdata_s[gi]),
         .fifo_reader_readflag_o  (rf_w[gi]),
         .fifo_reader_valid_o     (valid_w[gi]),
         .fifo_reader_ready_i     (ready_s[gi]),
         .fifo_reader_data_o      (data_w[gi]),
         .fifo_reader_busy_o      (busy_w[gi])
`ifdef FIFO_READER_CNT_EN
         ,
         .fifo_reader_count_o     (count_w[gi])
`endif
      );

      logic        v_prev = 1'b0, e_prev = 1'b1, en_prev = 1'b0, r_prev = 1'b1, x_prev = 1'b0;
      logic        pend = 1'b0, xseen = 1'b0, have_pop = 1'b0, empty_now, x_now;
      logic [31:0] d_prev = '0, pend_word = '0, last_x = '0;
      int          pend_edge = 0, dsr = 0, last_pop = 0;

      initial begin
         empty_s[gi] = 1'b1;
         rdata_s[gi] = '0;
      end

      // Fifo model and monitor: runs mid low-phase, after the stimulus for the
      // coming edge is settled, and judges what that edge will do.
      always @(negedge clk) begin
         #2;
         empty_now   = (wr_ptr[gi] == rd_ptr[gi]);
         empty_s[gi] = empty_now;
         // Read data is only meaningful in the single cycle it is due.
         rdata_s[gi] = (pend && (cyc == pend_edge + L)) ? pend_word : $urandom();
         if (r_prev) begin
            check(tg(gi, "rst_readflag"), rf_w[gi], 0);
            check(tg(gi, "rst_valid"), valid_w[gi], 0);
            check(tg(gi, "rst_busy"), busy_w[gi], 0);
            check(tg(gi, "rst_data"), data_w[gi], 0);
`ifdef FIFO_READER_CNT_EN
            check(tg(gi, "rst_count"), count_w[gi], 0);
`endif
         end else begin
            check(tg(gi, "busy"), busy_w[gi], (rf_w[gi] || (rd_ptr[gi] != exp_ptr[gi])) ? 1 : 0);
            if (rf_w[gi]) begin
               check(tg(gi, "pop_empty"), e_prev, 0);
               check(tg(gi, "pop_en"), en_prev, 1);
               check(tg(gi, "pop_holding"), valid_w[gi], 0);
               if (have_pop) check(tg(gi, "pop_gap_min"), (cyc - last_pop >= L + 3) ? 1 : 0, 1);
            end
            if (valid_w[gi] && !v_prev) begin
               check(tg(gi, "valid_lat"), pend ? (cyc - pend_edge) : -1, L + 1);
               pend = 1'b0;
            end
            if (valid_w[gi] && v_prev) check(tg(gi, "data_stable"), data_w[gi], d_prev);
            if (!valid_w[gi] && v_prev) check(tg(gi, "valid_drop"), x_prev, 1);
            if (!valid_w[gi] && xseen) check(tg(gi, "data_keep"), data_w[gi], last_x);
`ifdef FIFO_READER_CNT_EN
            check(tg(gi, "count"), count_w[gi], (dsr > 65535) ? 65535 : dsr);
`endif
         end
         x_now = valid_w[gi] && ready_s[gi] && !rst_s[gi];
         if (x_now) begin
            check(tg(gi, "xfer_data"), data_w[gi], mem[gi][exp_ptr[gi] % 256]);
            exp_ptr[gi]++;
            deliv[gi]++;
            dsr++;
            last_x = data_w[gi];
            xseen  = 1'b1;
         end
         if (rf_w[gi] && !empty_now) begin
            pend      = 1'b1;
            pend_edge = cyc;
            pend_word = mem[gi][rd_ptr[gi] % 256];
            rd_ptr[gi]++;
            pop_log[gi][pop_n[gi] % 16] = cyc;
            pop_n[gi]++;
            last_pop = cyc;
            have_pop = 1'b1;
         end
         if (rst_s[gi]) begin
            exp_ptr[gi] = rd_ptr[gi];
            pend     = 1'b0;
            xseen    = 1'b0;
            have_pop = 1'b0;
            dsr      = 0;
         end
         v_prev  = valid_w[gi];
         d_prev  = data_w[gi];
         e_prev  = empty_now;
         en_prev = en_s[gi];
         r_prev  = rst_s[gi];
         x_prev  = x_now;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic push(input int ln, input logic [31:0] w);
      mem[ln][wr_ptr[ln] % 256] = w;
      wr_ptr[ln]++;
   endtask

   task automatic wait_deliv(input int ln, input int target, input int budget, input string tag);
      int n = 0;
      while (deliv[ln] < target && n < budget) begin
         tick(1);
         n++;
      end
      check(tg(ln, tag), deliv[ln], target);
   endtask

   task automatic wait_pop(input int ln, input int target, input int budget, input string tag);
      int n = 0;
      while (pop_n[ln] < target && n < budget) begin
         tick(1);
         n++;
      end
      check(tg(ln, tag), pop_n[ln], target);
   endtask

   task automatic wait_valid(input int ln, input int budget, input string tag);
      int n = 0;
      while (!valid_w[ln] && n < budget) begin
         tick(1);
         n++;
      end
      check(tg(ln, tag), valid_w[ln], 1);
   endtask

   task automatic run_lane(input int ln);
      int L, base, d0, n;
      logic [31:0] w;
      L = lat_of(ln);

      // Reset held two cycles with the fifo empty, then enabled but empty.
      rst_s[ln] = 1'b1; en_s[ln] = 1'b0; ready_s[ln] = 1'b0;
      tick(2);
      rst_s[ln] = 1'b0; en_s[ln] = 1'b1;
      tick(6);
      check(tg(ln, "empty_nopop"), pop_n[ln], 0);
      check(tg(ln, "empty_busy"), busy_w[ln], 0);

      // Single word.
      ready_s[ln] = 1'b1;
      push(ln, 32'h0000AD00);
      wait_deliv(ln, 1, 40, "single_deliv");
      tick(3);
      check(tg(ln, "single_pops"), pop_n[ln], 1);
      check(tg(ln, "single_idle"), busy_w[ln], 0);

      // Back-to-back words at best throughput.
      base = pop_n[ln]; d0 = deliv[ln];
      push(ln, 32'h1); push(ln, 32'h2); push(ln, 32'h3); push(ln, 32'h5);
      wait_deliv(ln, d0 + 4, 100, "burst_deliv");
      for (int i = 1; i < 4; i++)
         check(tg(ln, "burst_gap"), pop_log[ln][(base + i) % 16] - pop_log[ln][(base + i - 1) % 16], L + 3);

      // Downstream stall in HOLD for ten cycles.
      base = pop_n[ln]; d0 = deliv[ln];
      ready_s[ln] = 1'b0;
      push(ln, 32'hCAFE0001); push(ln, 32'hCAFE0002);
      wait_valid(ln, 30, "stall_valid");
      tick(10);
      check(tg(ln, "stall_nopop"), pop_n[ln], base + 1);
      check(tg(ln, "stall_data"), data_w[ln], 32'hCAFE0001);
      ready_s[ln] = 1'b1;
      tick(1);
      check(tg(ln, "stall_one_xfer"), deliv[ln], d0 + 1);
      wait_deliv(ln, d0 + 2, 40, "stall_drain");

      // Enable dropped the cycle after a pop.
      base = pop_n[ln]; d0 = deliv[ln];
      push(ln, 32'h00E10001); push(ln, 32'h00E10002); push(ln, 32'h00E10003);
      wait_pop(ln, base + 1, 20, "en_first_pop");
      en_s[ln] = 1'b0;
      tick(L + 12);
      check(tg(ln, "en_deliv"), deliv[ln], d0 + 1);
      check(tg(ln, "en_nopop"), pop_n[ln], base + 1);
      en_s[ln] = 1'b1;
      wait_deliv(ln, d0 + 3, 60, "en_drain");

      // Randomised traffic.
      for (int c = 0; c < 400; c++) begin
         en_s[ln]    = ($urandom_range(0, 3) != 0);
         ready_s[ln] = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 3) == 0 && (wr_ptr[ln] - exp_ptr[ln]) < 200) push(ln, $urandom());
         tick(1);
      end
      en_s[ln] = 1'b1; ready_s[ln] = 1'b1;
      n = 0;
      while (exp_ptr[ln] != wr_ptr[ln] && n < 3000) begin
         tick(1);
         n++;
      end
      check(tg(ln, "rand_drain"), exp_ptr[ln], wr_ptr[ln]);
      tick(2);

      // Reset while waiting on read latency: word is dropped.
      base = pop_n[ln]; d0 = deliv[ln];
      push(ln, 32'hDEAD0001);
      wait_pop(ln, base + 1, 20, "rstw_pop");
      rst_s[ln] = 1'b1;
      tick(1);
      rst_s[ln] = 1'b0;
      check(tg(ln, "rstw_valid"), valid_w[ln], 0);
      check(tg(ln, "rstw_busy"), busy_w[ln], 0);
      tick(L + 10);
      check(tg(ln, "rstw_dropped"), deliv[ln], d0);

      // Reset while holding a word: word is dropped.
      d0 = deliv[ln];
      ready_s[ln] = 1'b0;
      push(ln, 32'hDEAD0002);
      wait_valid(ln, 30, "rsth_valid_up");
      rst_s[ln] = 1'b1;
      tick(1);
      rst_s[ln] = 1'b0;
      check(tg(ln, "rsth_valid"), valid_w[ln], 0);
      check(tg(ln, "rsth_busy"), busy_w[ln], 0);
      ready_s[ln] = 1'b1;
      tick(10);
      check(tg(ln, "rsth_dropped"), deliv[ln], d0);

      // A fresh word still flows after the resets.
      w = 32'h600D0000 | 32'(ln);
      push(ln, w);
      wait_deliv(ln, d0 + 1, 40, "post_rst_deliv");
      check(tg(ln, "final_sb"), exp_ptr[ln], wr_ptr[ln]);

      rst_s[ln] = 1'b1; en_s[ln] = 1'b0; ready_s[ln] = 1'b0;
      tick(2);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         rst_s[i] = 1'b1; en_s[i] = 1'b0; ready_s[i] = 1'b0;
      end
      for (int ln = 0; ln < 3; ln++) run_lane(ln);
      tick(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

endmodule
